// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and helpers for the SDRAM RAM-port arbiter.
//   arb_tag_t         outstanding-request tag {issuing port, remaining beats}
//   port_idx_w()      width of a port index for a given port count
//   OUTSTANDING_DEF   default tag FIFO depth
// Tag fields are sized for the largest supported configuration
// (NUM_PORTS <= 8, LEN_W <= 16); narrower configurations zero-extend.
package sdram_arb_pkg;

    localparam int unsigned OUTSTANDING_DEF = 4;
    localparam int unsigned TAG_PORT_W      = 3;
    localparam int unsigned TAG_BEAT_W      = 17;

    typedef struct packed {
        logic [TAG_PORT_W-1:0] port;
        logic [TAG_BEAT_W-1:0] beats;
    } arb_tag_t;

    function automatic int unsigned port_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: synchronous tag FIFO with asynchronous active-high reset.
//   clk_i, rst_i    clock, async reset
//   push_i          write push_tag_i at the tail
//   pop_i           drop the head entry
//   dec_i           decrement the head beat count in place (ignored when popping)
//   head_o          current head entry (valid when !empty_o)
//   full_o/empty_o  occupancy flags from registered count
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = OUTSTANDING_DEF
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  arb_tag_t push_tag_i,
    input  logic     pop_i,
    input  logic     dec_i,
    output arb_tag_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    arb_tag_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Push never targets the head slot: push needs !full, dec needs !empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= push_tag_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_i)
                rd_ptr <= rd_ptr + AW'(1);
            else if (dec_i)
                mem[rd_ptr].beats <= mem[rd_ptr].beats - TAG_BEAT_W'(1);
            case ({push_i, pop_i})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_o  = mem[rd_ptr];
    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);

endmodule

// File: rtl/sdram_ram_arbiter.sv
// sdram_ram_arbiter: round-robin arbiter sharing one sdram_axi_core RAM port
// between NUM_PORTS sdram_axi_pmem-style request ports.
//   in_*      per-port request fields (packed, port p at slice p) and
//             per-port accept/ack/error; in_read_data_o is shared
//   ram_*     downstream request mux and response inputs
//   orphan_ack_o  sticky: an ack arrived with no outstanding tag
// Optional macro SDRAM_ARB_LOCK_EN: hold the grant on one port for up to
// OUTSTANDING back-to-back accepts while it keeps requesting.
module sdram_ram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned OUTSTANDING = OUTSTANDING_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] in_wr_i,
    input  logic [NUM_PORTS-1:0]          in_rd_i,
    input  logic [NUM_PORTS*LEN_W-1:0]    in_len_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   in_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_write_data_i,
    output logic [NUM_PORTS-1:0]          in_accept_o,
    output logic [NUM_PORTS-1:0]          in_ack_o,
    output logic [NUM_PORTS-1:0]          in_error_o,
    output logic [DATA_W-1:0]             in_read_data_o,
    output logic [DATA_W/8-1:0]           ram_wr_o,
    output logic                          ram_rd_o,
    output logic [LEN_W-1:0]              ram_len_o,
    output logic [ADDR_W-1:0]             ram_addr_o,
    output logic [DATA_W-1:0]             ram_write_data_o,
    input  logic                          ram_accept_i,
    input  logic                          ram_ack_i,
    input  logic                          ram_error_i,
    input  logic [DATA_W-1:0]             ram_read_data_i,
    output logic                          orphan_ack_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PW     = port_idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0] req;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant;
    logic [PW-1:0]        next_ptr;
    logic                 any_req;
    logic                 accept;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 ack_hit;
    logic                 pop;
    logic                 dec;
    arb_tag_t             head_tag;
    arb_tag_t             push_tag;

    // Grant = requesting port with the smallest wrapped distance from rr_ptr.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        best_d = NUM_PORTS;
        d      = 0;
        grant  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            req[p] = (|in_wr_i[p*STRB_W +: STRB_W]) | in_rd_i[p];
            if (req[p]) begin
                d = (p >= 32'(rr_ptr)) ? p - 32'(rr_ptr) : p + NUM_PORTS - 32'(rr_ptr);
                if (d < best_d) begin
                    best_d = d;
                    grant  = PW'(p);
                end
            end
        end
        any_req  = |req;
        next_ptr = (32'(grant) == NUM_PORTS - 1) ? '0 : grant + PW'(1);
    end

    always_comb begin
        ram_wr_o         = '0;
        ram_rd_o         = 1'b0;
        ram_len_o        = '0;
        ram_addr_o       = '0;
        ram_write_data_o = '0;
        if (any_req && !fifo_full) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (PW'(p) == grant) begin
                    ram_wr_o         = in_wr_i[p*STRB_W +: STRB_W];
                    ram_rd_o         = in_rd_i[p] & ~(|in_wr_i[p*STRB_W +: STRB_W]);
                    ram_len_o        = in_len_i[p*LEN_W +: LEN_W];
                    ram_addr_o       = in_addr_i[p*ADDR_W +: ADDR_W];
                    ram_write_data_o = in_write_data_i[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign accept        = ram_accept_i & any_req & ~fifo_full;
    assign push_tag.port = TAG_PORT_W'(grant);
    assign push_tag.beats = (ram_wr_o != '0) ? TAG_BEAT_W'(1)
                                             : TAG_BEAT_W'(ram_len_o) + TAG_BEAT_W'(1);

    assign ack_hit = ram_ack_i & ~fifo_empty;
    assign pop     = ack_hit && (head_tag.beats == TAG_BEAT_W'(1));
    assign dec     = ack_hit && !pop;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            in_accept_o[p] = accept && (PW'(p) == grant);
            in_ack_o[p]    = ack_hit && (head_tag.port == TAG_PORT_W'(p));
            in_error_o[p]  = ack_hit && (head_tag.port == TAG_PORT_W'(p)) && ram_error_i;
        end
    end

    assign in_read_data_o = ram_read_data_i;

    sdram_arb_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (accept),
        .push_tag_i (push_tag),
        .pop_i      (pop),
        .dec_i      (dec),
        .head_o     (head_tag),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            orphan_ack_o <= 1'b0;
        else if (ram_ack_i && fifo_empty)
            orphan_ack_o <= 1'b1;
    end

`ifdef SDRAM_ARB_LOCK_EN
    localparam int unsigned LCW = $clog2(OUTSTANDING);

    logic [LCW-1:0] lock_cnt;
    logic [LCW-1:0] lock_base;
    logic           rr_req;

    // A grant landing on a different port than rr_ptr starts a fresh lock run.
    always_comb begin
        lock_base = (grant == rr_ptr) ? lock_cnt : '0;
        rr_req    = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++)
            if (PW'(p) == rr_ptr) rr_req = req[p];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock_cnt <= '0;
        end else if (accept) begin
            if (lock_base < LCW'(OUTSTANDING - 1)) begin
                rr_ptr   <= grant;
                lock_cnt <= lock_base + LCW'(1);
            end else begin
                rr_ptr   <= next_ptr;
                lock_cnt <= '0;
            end
        end else if (!rr_req) begin
            lock_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= next_ptr;
    end
`endif

endmodule

// File: tb/tb_sdram_ram_arbiter.sv
module tb_sdram_ram_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int OS = 4;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*SW-1:0]  in_wr_i;
    logic [NP-1:0]     in_rd_i;
    logic [NP*LW-1:0]  in_len_i;
    logic [NP*AW-1:0]  in_addr_i;
    logic [NP*DW-1:0]  in_write_data_i;
    logic [NP-1:0]     in_accept_o;
    logic [NP-1:0]     in_ack_o;
    logic [NP-1:0]     in_error_o;
    logic [DW-1:0]     in_read_data_o;
    logic [SW-1:0]     ram_wr_o;
    logic              ram_rd_o;
    logic [LW-1:0]     ram_len_o;
    logic [AW-1:0]     ram_addr_o;
    logic [DW-1:0]     ram_write_data_o;
    logic              ram_accept_i;
    logic              ram_ack_i;
    logic              ram_error_i;
    logic [DW-1:0]     ram_read_data_i;
    logic              orphan_ack_o;

    always #5 clk = ~clk;

    sdram_ram_arbiter #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .LEN_W       (LW),
        .OUTSTANDING (OS)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_wr_i          (in_wr_i),
        .in_rd_i          (in_rd_i),
        .in_len_i         (in_len_i),
        .in_addr_i        (in_addr_i),
        .in_write_data_i  (in_write_data_i),
        .in_accept_o      (in_accept_o),
        .in_ack_o         (in_ack_o),
        .in_error_o       (in_error_o),
        .in_read_data_o   (in_read_data_o),
        .ram_wr_o         (ram_wr_o),
        .ram_rd_o         (ram_rd_o),
        .ram_len_o        (ram_len_o),
        .ram_addr_o       (ram_addr_o),
        .ram_write_data_o (ram_write_data_o),
        .ram_accept_i     (ram_accept_i),
        .ram_ack_i        (ram_ack_i),
        .ram_error_i      (ram_error_i),
        .ram_read_data_i  (ram_read_data_i),
        .orphan_ack_o     (orphan_ack_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Upstream port state: p_cnt requests remain, each held until accepted.
    int          p_cnt [NP];
    bit          p_isw [NP];
    int          p_len [NP];
    logic [AW-1:0] p_addr [NP];
    logic [DW-1:0] p_data [NP];
    logic [SW-1:0] p_strb [NP];
    logic        r_acc, r_ack, r_err;

    // Reference model: queue of outstanding transactions in issue order.
    typedef struct { int port; int beats; } tag_t;
    tag_t m_q[$];
    int   m_rr, m_lock;
    bit   m_orphan;

    int   acc_log[$];
    int   ack_log[$];
    bit   err_log[$];
    logic [NP-1:0] obs_acc, obs_ack;
    logic          obs_rd;

    task automatic new_req(input int p);
        p_addr[p] = $urandom;
        p_data[p] = $urandom;
        p_strb[p] = SW'($urandom_range(1, (1 << SW) - 1));
    endtask

    task automatic apply();
        for (int p = 0; p < NP; p++) begin
            in_wr_i[p*SW +: SW]         = (p_cnt[p] > 0 && p_isw[p]) ? p_strb[p] : '0;
            in_rd_i[p]                  = (p_cnt[p] > 0 && !p_isw[p]);
            in_len_i[p*LW +: LW]        = LW'(p_len[p]);
            in_addr_i[p*AW +: AW]       = p_addr[p];
            in_write_data_i[p*DW +: DW] = p_data[p];
        end
        ram_accept_i    = r_acc;
        ram_ack_i       = r_ack;
        ram_error_i     = r_err;
        ram_read_data_i = $urandom;
    endtask

    // One clock: drive, compare against the model at negedge, advance model.
    task automatic tick();
        int g;
        bit full;
        logic [NP-1:0] e_acc, e_ack, e_err;
        logic [SW-1:0] e_wr;
        logic          e_rd;
        logic [LW-1:0] e_len;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        int base;
        apply();
        @(negedge clk);
        full = (m_q.size() >= OS);
        g = -1;
        for (int k = 0; k < NP; k++) begin
            int i = (m_rr + k) % NP;
            if (g < 0 && p_cnt[i] > 0) g = i;
        end
        e_acc = '0; e_ack = '0; e_err = '0;
        e_wr = '0; e_rd = 1'b0; e_len = '0; e_addr = '0; e_data = '0;
        if (g >= 0 && !full) begin
            e_wr   = p_isw[g] ? p_strb[g] : '0;
            e_rd   = !p_isw[g];
            e_len  = LW'(p_len[g]);
            e_addr = p_addr[g];
            e_data = p_data[g];
            if (r_acc) e_acc[g] = 1'b1;
        end
        if (r_ack && m_q.size() > 0) begin
            e_ack[m_q[0].port] = 1'b1;
            e_err[m_q[0].port] = r_err;
        end
        n_cmp++; if (in_accept_o !== e_acc) begin n_bad++; $display("FAIL accept: got %b want %b t=%0t", in_accept_o, e_acc, $time); end
        n_cmp++; if (in_ack_o !== e_ack) begin n_bad++; $display("FAIL ack: got %b want %b t=%0t", in_ack_o, e_ack, $time); end
        n_cmp++; if (in_error_o !== e_err) begin n_bad++; $display("FAIL error: got %b want %b t=%0t", in_error_o, e_err, $time); end
        n_cmp++; if (ram_wr_o !== e_wr) begin n_bad++; $display("FAIL ram_wr: got %h want %h t=%0t", ram_wr_o, e_wr, $time); end
        n_cmp++; if (ram_rd_o !== e_rd) begin n_bad++; $display("FAIL ram_rd: got %b want %b t=%0t", ram_rd_o, e_rd, $time); end
        n_cmp++; if (ram_len_o !== e_len) begin n_bad++; $display("FAIL ram_len: got %h want %h t=%0t", ram_len_o, e_len, $time); end
        n_cmp++; if (ram_addr_o !== e_addr) begin n_bad++; $display("FAIL ram_addr: got %h want %h t=%0t", ram_addr_o, e_addr, $time); end
        n_cmp++; if (ram_write_data_o !== e_data) begin n_bad++; $display("FAIL ram_wdata: got %h want %h t=%0t", ram_write_data_o, e_data, $time); end
        n_cmp++; if (in_read_data_o !== ram_read_data_i) begin n_bad++; $display("FAIL rdata: got %h want %h t=%0t", in_read_data_o, ram_read_data_i, $time); end
        n_cmp++; if (orphan_ack_o !== m_orphan) begin n_bad++; $display("FAIL orphan: got %b want %b t=%0t", orphan_ack_o, m_orphan, $time); end
        obs_acc = in_accept_o; obs_ack = in_ack_o; obs_rd = ram_rd_o;
        for (int p = 0; p < NP; p++) begin
            if (in_accept_o[p]) acc_log.push_back(p);
            if (in_ack_o[p]) begin ack_log.push_back(p); err_log.push_back(in_error_o[p]); end
        end
        @(posedge clk);
        if (r_ack) begin
            if (m_q.size() > 0) begin
                m_q[0].beats--;
                if (m_q[0].beats == 0) m_q.delete(0);
            end else begin
                m_orphan = 1'b1;
            end
        end
        if (e_acc != '0) begin
            tag_t t;
            t.port  = g;
            t.beats = p_isw[g] ? 1 : p_len[g] + 1;
            m_q.push_back(t);
`ifdef SDRAM_ARB_LOCK_EN
            base = (g == m_rr) ? m_lock : 0;
            if (base < OS - 1) begin m_rr = g; m_lock = base + 1; end
            else begin m_rr = (g + 1) % NP; m_lock = 0; end
`else
            base = 0;
            m_rr = (g + 1) % NP;
`endif
            p_cnt[g]--;
            new_req(g);
        end
`ifdef SDRAM_ARB_LOCK_EN
        else if (p_cnt[m_rr] == 0) m_lock = 0;
`endif
        #1;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < NP; p++) begin
            p_cnt[p] = 0; p_isw[p] = 1'b0; p_len[p] = 0; new_req(p);
        end
        r_acc = 1'b0; r_ack = 1'b0; r_err = 1'b0;
        apply();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_q.delete(); m_rr = 0; m_lock = 0; m_orphan = 1'b0;
        acc_log.delete(); ack_log.delete(); err_log.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (in_accept_o !== '0 || in_ack_o !== '0 || in_error_o !== '0) begin
            n_bad++; $display("FAIL reset_port_out: acc=%b ack=%b err=%b want 0", in_accept_o, in_ack_o, in_error_o); end
        n_cmp++; if (ram_wr_o !== '0 || ram_rd_o !== 1'b0 || ram_len_o !== '0 || ram_addr_o !== '0 || ram_write_data_o !== '0) begin
            n_bad++; $display("FAIL reset_ram_out: wr=%h rd=%b len=%h addr=%h want 0", ram_wr_o, ram_rd_o, ram_len_o, ram_addr_o); end
        n_cmp++; if (orphan_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_orphan: got %b want 0", orphan_ack_o); end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_two_reads();
        do_reset();
        for (int p = 0; p < 2; p++) begin p_cnt[p] = 1; p_isw[p] = 1'b0; p_len[p] = 3; end
        r_acc = 1'b1;
        repeat (2) tick();
        r_ack = 1'b1;
        repeat (8) tick();
        r_ack = 1'b0;
        tick();
        n_cmp++; if (acc_log.size() != 2 || acc_log[0] != 0 || acc_log[1] != 1) begin
            n_bad++; $display("FAIL two_reads_order: got %p want '{0,1}", acc_log); end
        n_cmp++; if (ack_log.size() != 8) begin n_bad++; $display("FAIL two_reads_acks: got %0d want 8", ack_log.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_cmp++; if (ack_log[i] != (i < 4 ? 0 : 1)) begin
                n_bad++; $display("FAIL two_reads_route[%0d]: got port %0d want %0d", i, ack_log[i], i < 4 ? 0 : 1); end
        end
    endtask

    task automatic test_rotation();
        int cnt[NP];
        do_reset();
        for (int p = 0; p < NP; p++) begin p_cnt[p] = 5; p_isw[p] = 1'b1; cnt[p] = 0; end
        r_acc = 1'b1;
        repeat (16) begin r_ack = (m_q.size() > 0); tick(); end
        foreach (acc_log[i]) cnt[acc_log[i]]++;
        n_cmp++; if (acc_log.size() != 16) begin n_bad++; $display("FAIL rotation_total: got %0d want 16", acc_log.size()); end
`ifndef SDRAM_ARB_LOCK_EN
        for (int i = 0; i < 5 && i < acc_log.size(); i++) begin
            n_cmp++; if (acc_log[i] != i % NP) begin n_bad++; $display("FAIL rotation_seq[%0d]: got %0d want %0d", i, acc_log[i], i % NP); end
        end
        for (int p = 0; p < NP; p++) begin
            n_cmp++; if (cnt[p] != 4) begin n_bad++; $display("FAIL rotation_share[%0d]: got %0d want 4", p, cnt[p]); end
        end
`endif
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int p = 0; p < NP; p++) begin p_cnt[p] = 1; p_isw[p] = 1'b0; p_len[p] = 1; end
        p_cnt[0] = 2;
        r_acc = 1'b1;
        repeat (4) tick();
        tick();
        n_cmp++; if (obs_acc !== '0 || obs_rd !== 1'b0) begin n_bad++; $display("FAIL full_block: acc=%b rd=%b want 0 0", obs_acc, obs_rd); end
        r_ack = 1'b1;
        tick();
        tick();
        n_cmp++; if (obs_acc !== '0) begin n_bad++; $display("FAIL full_pop_same_cycle: acc=%b want 0", obs_acc); end
        r_ack = 1'b0;
        tick();
        n_cmp++; if (obs_acc !== 4'b0001) begin n_bad++; $display("FAIL full_release: acc=%b want 0001", obs_acc); end
    endtask

    task automatic test_orphan();
        do_reset();
        r_ack = 1'b1;
        tick();
        n_cmp++; if (obs_ack !== '0) begin n_bad++; $display("FAIL orphan_no_ack: got %b want 0", obs_ack); end
        r_ack = 1'b0;
        repeat (5) tick();
        n_cmp++; if (orphan_ack_o !== 1'b1) begin n_bad++; $display("FAIL orphan_sticky: got %b want 1", orphan_ack_o); end
        do_reset();
        #1;
        n_cmp++; if (orphan_ack_o !== 1'b0) begin n_bad++; $display("FAIL orphan_clear: got %b want 0", orphan_ack_o); end
    endtask

    task automatic test_long_burst();
        int n1, nerr, eidx;
        do_reset();
        p_cnt[1] = 1; p_isw[1] = 1'b0; p_len[1] = 255;
        r_acc = 1'b1;
        tick();
        r_ack = 1'b1;
        for (int b = 1; b <= 256; b++) begin r_err = (b == 100); tick(); end
        r_ack = 1'b0; r_err = 1'b0;
        tick();
        n1 = 0; nerr = 0; eidx = -1;
        foreach (ack_log[i]) if (ack_log[i] == 1) n1++;
        foreach (err_log[i]) if (err_log[i]) begin nerr++; eidx = i + 1; end
        n_cmp++; if (n1 != 256) begin n_bad++; $display("FAIL burst_beats: got %0d want 256", n1); end
        n_cmp++; if (nerr != 1 || eidx != 100) begin n_bad++; $display("FAIL burst_error: got %0d errors at beat %0d want 1 at 100", nerr, eidx); end
    endtask

`ifdef SDRAM_ARB_LOCK_EN
    task automatic test_lock();
        int want[7] = '{0, 0, 0, 0, 1, 0, 0};
        do_reset();
        p_cnt[0] = 6; p_isw[0] = 1'b1;
        p_cnt[1] = 1; p_isw[1] = 1'b1;
        r_acc = 1'b1;
        for (int c = 0; c < 30 && acc_log.size() < 7; c++) begin r_ack = (m_q.size() > 0); tick(); end
        n_cmp++; if (acc_log.size() != 7) begin n_bad++; $display("FAIL lock_count: got %0d want 7", acc_log.size()); end
        else for (int i = 0; i < 7; i++) begin
            n_cmp++; if (acc_log[i] != want[i]) begin n_bad++; $display("FAIL lock_seq[%0d]: got %0d want %0d", i, acc_log[i], want[i]); end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        repeat (400) begin
            for (int p = 0; p < NP; p++) begin
                if (p_cnt[p] == 0 && $urandom_range(0, 9) == 0) begin
                    p_cnt[p] = $urandom_range(1, 4);
                    p_isw[p] = $urandom_range(0, 1);
                    p_len[p] = $urandom_range(0, 7);
                end
            end
            r_acc = ($urandom_range(0, 99) < 70);
            r_ack = (m_q.size() > 0) && ($urandom_range(0, 99) < 60);
            r_err = ($urandom_range(0, 4) == 0);
            tick();
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        p_cnt[2] = 1; p_isw[2] = 1'b0; p_len[2] = 7;
        r_acc = 1'b1;
        tick();
        r_ack = 1'b1;
        repeat (2) tick();
        r_ack = 1'b0; r_acc = 1'b0;
        apply();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (in_ack_o !== '0 || in_accept_o !== '0 || ram_rd_o !== 1'b0 || orphan_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL flush_async: ack=%b acc=%b rd=%b orphan=%b want all 0", in_ack_o, in_accept_o, ram_rd_o, orphan_ack_o); end
        @(posedge clk); #1 rst = 1'b0;
        m_q.delete(); m_rr = 0; m_lock = 0; m_orphan = 1'b0;
        ack_log.delete();
        r_ack = 1'b1;
        repeat (2) tick();
        r_ack = 1'b0;
        tick();
        n_cmp++; if (ack_log.size() != 0) begin n_bad++; $display("FAIL flush_no_route: got %0d acks want 0", ack_log.size()); end
        n_cmp++; if (orphan_ack_o !== 1'b1) begin n_bad++; $display("FAIL flush_orphan: got %b want 1", orphan_ack_o); end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_two_reads();
        test_rotation();
        test_fifo_full();
        test_orphan();
        test_long_burst();
`ifdef SDRAM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
